// File: rtl/bp_fe_fetch_buffer_ctrl.sv
// Front-end fetch control and decoupling buffer: credit-gated issue, epoch-tagged fetches, multi-lane FIFO.
// Optional same-cycle bypass of an empty FIFO is enabled by defining BP_FE_FETCH_BUF_BYPASS_EN.
module bp_fe_fetch_buffer_ctrl #(
    parameter int vaddr_width_p  = 39,
    parameter int instr_width_p  = 32,
    parameter int fetch_width_p  = 2,
    parameter int depth_p        = 8,
    parameter int max_inflight_p = 2,
    parameter int epoch_width_p  = 2,
    parameter int exc_width_p    = 2
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   redirect_v_i,
    input  logic                                   fetch_req_ready_i,
    output logic                                   fetch_req_v_o,
    output logic [epoch_width_p-1:0]               fetch_req_epoch_o,
    input  logic                                   resp_v_i,
    input  logic [epoch_width_p-1:0]               resp_epoch_i,
    input  logic [vaddr_width_p-1:0]               resp_pc_i,
    input  logic [fetch_width_p*instr_width_p-1:0] resp_instr_i,
    input  logic [fetch_width_p-1:0]               resp_mask_i,
    input  logic                                   resp_exc_v_i,
    input  logic [exc_width_p-1:0]                 resp_exc_code_i,
    output logic                                   out_v_o,
    input  logic                                   out_ready_i,
    output logic [vaddr_width_p-1:0]               out_pc_o,
    output logic [instr_width_p-1:0]               out_instr_o,
    output logic                                   out_exc_v_o,
    output logic [exc_width_p-1:0]                 out_exc_code_o,
    output logic [1:0]                             state_o,
    output logic [$clog2(depth_p+1)-1:0]           count_o
);
    localparam int CW = $clog2(depth_p + 1);
    localparam int PW = (depth_p > 1) ? $clog2(depth_p) : 1;
    localparam int IW = $clog2(max_inflight_p + 1);

    localparam logic [1:0] ST_WAIT  = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    typedef struct packed {
        logic [vaddr_width_p-1:0] pc;
        logic [instr_width_p-1:0] instr;
        logic                     exc_v;
        logic [exc_width_p-1:0]   exc_code;
    } entry_t;

    logic [1:0]               state_q, state_d;
    logic [epoch_width_p-1:0] epoch_q, epoch_d;
    logic [IW-1:0]            inflight_q, inflight_d;
    logic [PW-1:0]            rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0]            count_q, count_d;
    entry_t                   mem_q [depth_p];
    entry_t                   mem_d [depth_p];

    entry_t      head, out_e, lane_e;
    logic        accept, fifo_deq, lane_v;
    int unsigned n_slot, skip;
`ifdef BP_FE_FETCH_BUF_BYPASS_EN
    logic        byp_v;
    entry_t      byp_e;
`endif

    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int unsigned n);
        int unsigned s;
        s = 32'(p) + n;
        if (s >= 32'(depth_p)) s = s - 32'(depth_p);
        return PW'(s);
    endfunction

    always_comb begin
        fetch_req_v_o = fetch_req_ready_i && (state_q == ST_STALL || state_q == ST_RUN) && !redirect_v_i
                        && (32'(inflight_q) < 32'(max_inflight_p))
                        && ((32'(depth_p) - 32'(count_q)) >= (32'(inflight_q) + 32'd1) * 32'(fetch_width_p));
        accept = resp_v_i && (state_q != ST_WAIT) && (resp_epoch_i == epoch_q) && !redirect_v_i;
        head   = mem_q[rptr_q];
        mem_d  = mem_q;
        n_slot = 0;
        skip   = 0;
        lane_e = '0;
        lane_v = 1'b0;
`ifdef BP_FE_FETCH_BUF_BYPASS_EN
        byp_v  = 1'b0;
        byp_e  = '0;
`endif
        // Set lanes are packed into consecutive slots; an exception occupies lane 0 alone.
        for (int unsigned k = 0; k < fetch_width_p; k++) begin
            lane_e.pc       = resp_pc_i + vaddr_width_p'(4 * k);
            lane_e.instr    = resp_instr_i[k*instr_width_p +: instr_width_p];
            lane_e.exc_v    = 1'b0;
            lane_e.exc_code = '0;
            lane_v          = accept && !resp_exc_v_i && resp_mask_i[k];
            if (k == 0 && accept && resp_exc_v_i) begin
                lane_e.instr    = '0;
                lane_e.exc_v    = 1'b1;
                lane_e.exc_code = resp_exc_code_i;
                lane_v          = 1'b1;
            end
            if (lane_v) begin
`ifdef BP_FE_FETCH_BUF_BYPASS_EN
                if (n_slot == 0 && count_q == '0) begin
                    byp_v = 1'b1;
                    byp_e = lane_e;
                    skip  = out_ready_i ? 1 : 0;
                end
`endif
                if (n_slot >= skip) mem_d[ptr_add(wptr_q, n_slot - skip)] = lane_e;
                n_slot++;
            end
        end

`ifdef BP_FE_FETCH_BUF_BYPASS_EN
        out_v_o = (count_q != '0) || byp_v;
        out_e   = (count_q != '0) ? head : byp_e;
`else
        out_v_o = (count_q != '0);
        out_e   = head;
`endif
        fifo_deq = out_v_o && out_ready_i && (count_q != '0) && !redirect_v_i;

        if (redirect_v_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            rptr_d  = fifo_deq ? ptr_add(rptr_q, 1) : rptr_q;
            wptr_d  = ptr_add(wptr_q, n_slot - skip);
            count_d = CW'(32'(count_q) + n_slot - skip - (fifo_deq ? 32'd1 : 32'd0));
        end

        state_d = state_q;
        if (redirect_v_i) begin
            state_d = ST_STALL;
        end else if (state_q == ST_STALL && fetch_req_v_o) begin
            state_d = ST_RUN;
        end else if (state_q == ST_RUN && accept && resp_exc_v_i) begin
            state_d = ST_WAIT;
        end

        epoch_d    = epoch_q + epoch_width_p'(redirect_v_i);
        inflight_d = inflight_q + IW'(fetch_req_v_o) - IW'(resp_v_i);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_WAIT;
            epoch_q    <= '0;
            inflight_q <= '0;
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            epoch_q    <= epoch_d;
            inflight_q <= inflight_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign fetch_req_epoch_o = epoch_q;
    assign out_pc_o          = out_e.pc;
    assign out_instr_o       = out_e.instr;
    assign out_exc_v_o       = out_e.exc_v;
    assign out_exc_code_o    = out_e.exc_code;
    assign state_o           = state_q;
    assign count_o           = count_q;

endmodule

// File: tb/tb_bp_fe_fetch_buffer_ctrl.sv
// Randomized bench for bp_fe_fetch_buffer_ctrl against a queue-based reference model.
module tb_bp_fe_fetch_buffer_ctrl;
    localparam int VA    = 39;
    localparam int IWD   = 32;
    localparam int FW    = 2;
    localparam int DEPTH = 8;
    localparam int MAXI  = 2;
    localparam int EW    = 2;
    localparam int XW    = 2;

    logic              clk;
    logic              reset_n_i;
    logic              redirect_v_i;
    logic              fetch_req_ready_i;
    logic              fetch_req_v_o;
    logic [EW-1:0]     fetch_req_epoch_o;
    logic              resp_v_i;
    logic [EW-1:0]     resp_epoch_i;
    logic [VA-1:0]     resp_pc_i;
    logic [FW*IWD-1:0] resp_instr_i;
    logic [FW-1:0]     resp_mask_i;
    logic              resp_exc_v_i;
    logic [XW-1:0]     resp_exc_code_i;
    logic              out_v_o;
    logic              out_ready_i;
    logic [VA-1:0]     out_pc_o;
    logic [IWD-1:0]    out_instr_o;
    logic              out_exc_v_o;
    logic [XW-1:0]     out_exc_code_o;
    logic [1:0]        state_o;
    logic [3:0]        count_o;

    bp_fe_fetch_buffer_ctrl #(
        .vaddr_width_p(VA), .instr_width_p(IWD), .fetch_width_p(FW), .depth_p(DEPTH),
        .max_inflight_p(MAXI), .epoch_width_p(EW), .exc_width_p(XW)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .redirect_v_i(redirect_v_i),
        .fetch_req_ready_i(fetch_req_ready_i), .fetch_req_v_o(fetch_req_v_o),
        .fetch_req_epoch_o(fetch_req_epoch_o), .resp_v_i(resp_v_i), .resp_epoch_i(resp_epoch_i),
        .resp_pc_i(resp_pc_i), .resp_instr_i(resp_instr_i), .resp_mask_i(resp_mask_i),
        .resp_exc_v_i(resp_exc_v_i), .resp_exc_code_i(resp_exc_code_i), .out_v_o(out_v_o),
        .out_ready_i(out_ready_i), .out_pc_o(out_pc_o), .out_instr_o(out_instr_o),
        .out_exc_v_o(out_exc_v_o), .out_exc_code_o(out_exc_code_o), .state_o(state_o),
        .count_o(count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [VA-1:0]  pc;
        logic [IWD-1:0] instr;
        logic           exc;
        logic [XW-1:0]  code;
    } ent_t;

    ent_t          mq[$];
    logic [EW-1:0] pend[$];
    int            m_state;
    int            m_inflight;
    logic [EW-1:0] m_epoch;
    int            n_tests;
    int            n_fail;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called with inputs stable after a negedge; checks outputs, then advances the model one clock.
    task automatic eval_step();
        ent_t ents[$];
        ent_t e;
        ent_t o;
        bit   acc, iss, ov, byp;
        #1;
        acc = resp_v_i && m_state != 0 && resp_epoch_i == m_epoch && !redirect_v_i;
        if (acc) begin
            if (resp_exc_v_i) begin
                e.pc = resp_pc_i; e.instr = '0; e.exc = 1'b1; e.code = resp_exc_code_i;
                ents.push_back(e);
            end else begin
                for (int k = 0; k < FW; k++) begin
                    if (resp_mask_i[k]) begin
                        e.pc = resp_pc_i + 39'(4 * k);
                        e.instr = resp_instr_i[k*IWD +: IWD];
                        e.exc = 1'b0; e.code = '0;
                        ents.push_back(e);
                    end
                end
            end
        end
        iss = fetch_req_ready_i && (m_state == 1 || m_state == 2) && !redirect_v_i
              && m_inflight < MAXI && (DEPTH - mq.size()) >= (m_inflight + 1) * FW;
        byp = 1'b0;
`ifdef BP_FE_FETCH_BUF_BYPASS_EN
        byp = (mq.size() == 0) && (ents.size() > 0);
`endif
        ov = (mq.size() > 0) || byp;
        o  = '{default: '0};
        if (mq.size() > 0) o = mq[0];
        else if (byp) o = ents[0];

        check_eq("fetch_req_v", fetch_req_v_o, iss);
        if (iss) check_eq("fetch_req_epoch", fetch_req_epoch_o, m_epoch);
        check_eq("state", state_o, m_state);
        check_eq("count", count_o, mq.size());
        check_eq("out_v", out_v_o, ov);
        if (ov) begin
            check_eq("out_pc", out_pc_o, o.pc);
            check_eq("out_exc_v", out_exc_v_o, o.exc);
            if (o.exc) check_eq("out_exc_code", out_exc_code_o, o.code);
            else check_eq("out_instr", out_instr_o, o.instr);
        end

        if (resp_v_i) pend.delete(0);
        if (iss) pend.push_back(m_epoch);
        m_inflight = m_inflight + int'(iss) - int'(resp_v_i);
        if (redirect_v_i) begin
            mq.delete();
            m_epoch++;
            m_state = 1;
        end else begin
            if (ov && out_ready_i) begin
                if (mq.size() > 0) mq.delete(0);
                else ents.delete(0);
            end
            foreach (ents[i]) mq.push_back(ents[i]);
            if (m_state == 1 && iss) m_state = 2;
            else if (m_state == 2 && acc && resp_exc_v_i) m_state = 0;
        end
        @(posedge clk);
    endtask

    task automatic drive_rand(input int ready_pct, input bit allow_exc, input int redir_pct);
        @(negedge clk);
        redirect_v_i      = (m_state == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) < redir_pct);
        fetch_req_ready_i = ($urandom_range(0, 3) != 0);
        resp_v_i          = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
        resp_epoch_i      = resp_v_i ? pend[0] : 2'($urandom);
        resp_pc_i         = ($urandom_range(0, 7) == 0) ? ({VA{1'b1}} - 39'($urandom_range(0, 8)))
                                                        : {7'($urandom), 32'($urandom)};
        resp_instr_i      = {32'($urandom), 32'($urandom)};
        resp_mask_i       = 2'($urandom);
        resp_exc_v_i      = allow_exc && ($urandom_range(0, 15) == 0);
        resp_exc_code_i   = 2'($urandom);
        out_ready_i       = ($urandom_range(0, 99) < ready_pct);
        eval_step();
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        m_state = 0; m_inflight = 0; m_epoch = '0;
        reset_n_i = 1'b0; redirect_v_i = 1'b0; fetch_req_ready_i = 1'b1;
        resp_v_i = 1'b0; resp_epoch_i = '0; resp_pc_i = '0; resp_instr_i = '0;
        resp_mask_i = '0; resp_exc_v_i = 1'b0; resp_exc_code_i = '0; out_ready_i = 1'b1;

        #3;
        check_eq("rst_state", state_o, 0);
        check_eq("rst_count", count_o, 0);
        check_eq("rst_out_v", out_v_o, 0);
        check_eq("rst_fetch_req_v", fetch_req_v_o, 0);

        @(negedge clk);
        reset_n_i = 1'b1;
        redirect_v_i = 1'b1;
        eval_step();

        @(negedge clk);
        redirect_v_i = 1'b0;
        #1;
        check_eq("first_issue_v", fetch_req_v_o, 1);
        check_eq("first_issue_epoch", fetch_req_epoch_o, 1);
        check_eq("stall_state", state_o, 1);
        eval_step();

        @(negedge clk);
        fetch_req_ready_i = 1'b0;
        resp_v_i = 1'b1; resp_epoch_i = pend[0]; resp_pc_i = 39'h1000;
        resp_instr_i = 64'h1111_2222_3333_4444; resp_mask_i = 2'b11;
        #1;
        check_eq("run_state", state_o, 2);
        eval_step();

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            resp_v_i = 1'b0;
            eval_step();
        end

        for (int i = 0; i < 3000; i++) drive_rand(70, 1'b1, 6);
        for (int i = 0; i < 1500; i++) drive_rand(20, 1'b1, 6);
        for (int i = 0; i < 1500; i++) drive_rand(100, 1'b1, 3);
        for (int i = 0; i < 60; i++) drive_rand(0, 1'b0, 0);

        @(negedge clk);
        redirect_v_i = 1'b0; fetch_req_ready_i = 1'b1; resp_v_i = 1'b0;
        #2;
        reset_n_i = 1'b0;
        #1;
        check_eq("async_rst_out_v", out_v_o, 0);
        check_eq("async_rst_count", count_o, 0);
        check_eq("async_rst_state", state_o, 0);
        check_eq("async_rst_fetch_req_v", fetch_req_v_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
